// File: rtl/extmem_arbiter.sv
// Round-robin burst arbiter sharing one external RAM port among NREQ requesters.
// Optional per-port beat counters are compiled in when EXTMEM_ARB_STATS_EN is defined.
`ifndef DATA_EXT_RAM
`define DATA_EXT_RAM 32
`endif
`ifndef ADDR_EXT_RAM
`define ADDR_EXT_RAM 24
`endif

module extmem_arbiter #(
  parameter int NREQ      = 3,
  parameter int BURST_MAX = 16,
  parameter int DW        = `DATA_EXT_RAM,
  parameter int AW        = `ADDR_EXT_RAM
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 mem_re,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [DW-1:0]        mem_rd_data,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_wr_addr,
  output logic [DW-1:0]        mem_wr_data
`ifdef EXTMEM_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [NREQ*32-1:0]   stat_beats
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_rd_addr_q, mem_rd_addr_d;
  logic [AW-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [DW-1:0]   mem_wr_data_q, mem_wr_data_d;

  // Read tag pipeline: stage 1 lines up with mem_re, stage 2 with mem_rd_data.
  logic            rd_v1_q, rd_v1_d, rd_v2_q, rd_v2_d;
  logic [PW-1:0]   rd_tag1_q, rd_tag1_d, rd_tag2_q, rd_tag2_d;

  logic [AW-1:0]   addr_a  [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];
  logic            own_valid, own_we, own_last;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;
  logic [PW-1:0]   pick;

  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [PW-1:0]   start);
    logic [PW-1:0] sel;
    int            idx;
    sel = start;
    // Scan from farthest to nearest so the nearest requester at/after start wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NREQ;
      if (v[idx]) sel = PW'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
    end
  end

  assign own_valid = req_valid[owner_q];
  assign own_we    = req_we[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_addr  = addr_a[owner_q];
  assign own_wdata = wdata_a[owner_q];
  assign pick      = rr_pick(req_valid, rr_ptr_q);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    req_ready     = '0;
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_v1_d       = 1'b0;
    rd_tag1_d     = rd_tag1_q;
    rd_v2_d       = rd_v1_q;
    rd_tag2_d     = rd_tag1_q;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d    = pick;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        req_ready[owner_q] = 1'b1;
        if (own_valid) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (own_we) begin
            mem_we_d      = 1'b1;
            mem_wr_addr_d = own_addr;
            mem_wr_data_d = own_wdata;
          end else begin
            mem_re_d      = 1'b1;
            mem_rd_addr_d = own_addr;
            rd_v1_d       = 1'b1;
            rd_tag1_d     = owner_q;
          end
          if (own_last || beat_cnt_q == CW'(BURST_MAX - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; every
  // register here is control or output state and gets an explicit reset value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      rd_v1_q       <= 1'b0;
      rd_v2_q       <= 1'b0;
      rd_tag1_q     <= '0;
      rd_tag2_q     <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_v1_q       <= rd_v1_d;
      rd_v2_q       <= rd_v2_d;
      rd_tag1_q     <= rd_tag1_d;
      rd_tag2_q     <= rd_tag2_d;
    end
  end

  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;

  always_comb begin
    rsp_valid = '0;
    if (rd_v2_q) rsp_valid[rd_tag2_q] = 1'b1;
  end

  // Gated so the shared bus reads zero whenever no response is due (including reset).
  assign rsp_data = rd_v2_q ? mem_rd_data : '0;

`ifdef EXTMEM_ARB_STATS_EN
  logic        beat_acc;
  logic [31:0] stat_q [NREQ];

  assign beat_acc = (state_q == BUSY) && own_valid;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n || stat_clr) begin
        stat_q[i] <= '0;
      end else if (beat_acc && owner_q == PW'(i) && stat_q[i] != 32'hFFFF_FFFF) begin
        stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) stat_beats[i*32 +: 32] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_extmem_arbiter.sv
// Self-checking bench for extmem_arbiter: directed scenarios plus a random phase,
// all checked every cycle against a transaction-level model with a read scoreboard.
`timescale 1ns/1ps
module tb_extmem_arbiter;
  localparam int NREQ = 3, BURST_MAX = 16, DW = 32, AW = 24;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid, req_ready, req_we, req_last, rsp_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [DW-1:0]       rsp_data, mem_rd_data, mem_wr_data;
  logic                mem_re, mem_we;
  logic [AW-1:0]       mem_rd_addr, mem_wr_addr;
`ifdef EXTMEM_ARB_STATS_EN
  logic                stat_clr;
  logic [NREQ*32-1:0]  stat_beats;
`endif

  always #5 clk = ~clk;

  extmem_arbiter #(.NREQ(NREQ), .BURST_MAX(BURST_MAX), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_re(mem_re), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
`ifdef EXTMEM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(stat_beats)
`endif
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External RAM: one-cycle read latency, driven only by the DUT's memory port.
  logic [DW-1:0] phys [int];
  always @(posedge clk) begin
    if (mem_we === 1'b1) phys[int'(mem_wr_addr)] = mem_wr_data;
    if (mem_re === 1'b1)
      mem_rd_data <= phys.exists(int'(mem_rd_addr)) ? phys[int'(mem_rd_addr)] : '0;
  end

  // Reference model: who holds the grant, how many beats it has used, where the
  // round-robin search starts, and which read responses are due on which cycle.
  typedef struct { int due; int port; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq[$];
  logic [DW-1:0] shadow [int];
  bit            model_en = 1'b0;
  bit            m_busy = 1'b0;
  int            m_own = 0, m_rr = 0, m_cnt = 0, cyc = 0;
  bit            exp_we = 1'b0, exp_re = 1'b0;
  logic [AW-1:0] exp_wa = '0, exp_ra = '0;
  logic [DW-1:0] exp_wd = '0;
  logic [31:0]   m_stat [NREQ];

  always @(negedge clk) begin : model
    logic [NREQ-1:0] exp_rv;
    logic [DW-1:0]   exp_rd, a_data;
    logic [AW-1:0]   a_addr;
    int              acc_p;
    cyc++;
    if (model_en) begin
      check("req_ready", 64'(req_ready), m_busy ? 64'(1 << m_own) : 64'd0);
      check("mem_we", 64'(mem_we), 64'(exp_we));
      if (exp_we) begin
        check("mem_wr_addr", 64'(mem_wr_addr), 64'(exp_wa));
        check("mem_wr_data", 64'(mem_wr_data), 64'(exp_wd));
      end
      check("mem_re", 64'(mem_re), 64'(exp_re));
      if (exp_re) check("mem_rd_addr", 64'(mem_rd_addr), 64'(exp_ra));
      check("re_we_exclusive", 64'(mem_re & mem_we), 64'd0);
      exp_rv = '0;
      exp_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_rv = NREQ'(1 << rq[0].port);
        exp_rd = rq[0].data;
        void'(rq.pop_front());
      end
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv != 0) check("rsp_data", 64'(rsp_data), 64'(exp_rd));
`ifdef EXTMEM_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) check("stat_beats", 64'(stat_beats[i*32 +: 32]), 64'(m_stat[i]));
`endif

      exp_we = 1'b0;
      exp_re = 1'b0;
      acc_p  = -1;
      if (!rst_n) begin
        m_busy = 1'b0; m_own = 0; m_rr = 0; m_cnt = 0;
        rq.delete();
      end else if (m_busy) begin
        if (req_valid[m_own]) begin
          acc_p  = m_own;
          a_addr = req_addr[m_own*AW +: AW];
          a_data = req_wdata[m_own*DW +: DW];
          if (req_we[m_own]) begin
            exp_we = 1'b1; exp_wa = a_addr; exp_wd = a_data;
            shadow[int'(a_addr)] = a_data;
          end else begin
            exp_re = 1'b1; exp_ra = a_addr;
            rq.push_back('{cyc + 2, m_own,
                           shadow.exists(int'(a_addr)) ? shadow[int'(a_addr)] : '0});
          end
          m_cnt++;
          if (req_last[m_own] || m_cnt == BURST_MAX) begin
            m_busy = 1'b0;
            m_rr   = (m_own + 1) % NREQ;
          end
        end
      end else if (req_valid != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (req_valid[(m_rr + k) % NREQ]) begin
            m_own = (m_rr + k) % NREQ;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
      for (int i = 0; i < NREQ; i++) begin
`ifdef EXTMEM_ARB_STATS_EN
        if (!rst_n || stat_clr) m_stat[i] = '0;
        else if (acc_p == i && m_stat[i] != 32'hFFFF_FFFF) m_stat[i] = m_stat[i] + 1;
`else
        if (acc_p == i) m_stat[i] = m_stat[i] + 1;
`endif
      end
    end
  end

  task automatic drive(input int p, input bit v, input bit we, input bit last,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p] = v;
    req_we[p]    = we;
    req_last[p]  = last;
    req_addr[p*AW +: AW]  = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  // Acceptance is sampled mid-cycle; inputs change 1ns after the following edge.
  task automatic tick(output logic [NREQ-1:0] acc);
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  logic [NREQ-1:0] acc;
  int n, b;
  int seq[$], when[$];
  int left[NREQ];

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
`ifdef EXTMEM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin m_stat[i] = '0; left[i] = 0; end
    repeat (2) @(posedge clk);
    #1 model_en = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_mem_wr_addr", 64'(mem_wr_addr), 64'd0);
    check("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single read on port 0, response two cycles after acceptance.
    phys[4194304] = 32'hA5;
    shadow[4194304] = 32'hA5;
    drive(0, 1, 0, 1, 24'd4194304, '0);
    n = 0;
    do begin tick(acc); n++; end while (acc == 0 && n < 10);
    check("rd_grant_latency", 64'(n), 64'd2);
    check("rd_accept_port", 64'(acc), 64'b001);
    drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("rd_mem_re", 64'(mem_re), 64'd1);
    check("rd_mem_rd_addr", 64'(mem_rd_addr), 64'd4194304);
    check("rd_rsp_not_early", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("rd_rsp_valid", 64'(rsp_valid), 64'b001);
    check("rd_rsp_data", 64'(rsp_data), 64'hA5);
    @(posedge clk); #1;

    // Single write on port 2.
    drive(2, 1, 1, 1, 24'd7398528, 32'd5);
    n = 0;
    do begin tick(acc); n++; end while (acc == 0 && n < 10);
    check("wr_grant_latency", 64'(n), 64'd2);
    check("wr_accept_port", 64'(acc), 64'b100);
    drive(2, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("wr_mem_we", 64'(mem_we), 64'd1);
    check("wr_mem_wr_addr", 64'(mem_wr_addr), 64'd7398528);
    check("wr_mem_wr_data", 64'(mem_wr_data), 64'd5);
    check("wr_back_to_idle", 64'(req_ready), 64'd0);
    @(posedge clk); #1;

    // Round robin with all ports requesting single-beat reads.
    for (int p = 0; p < NREQ; p++) drive(p, 1, 0, 1, AW'(32'h100 + p), '0);
    n = 0;
    while (seq.size() < 6 && n < 60) begin
      tick(acc); n++;
      if (acc != 0) begin seq.push_back(idx_of(acc)); when.push_back(n); end
    end
    check("rr_count", 64'(seq.size()), 64'd6);
    for (int i = 0; i < seq.size(); i++) begin
      check("rr_order", 64'(seq[i]), 64'(i % 3));
      if (i > 0) check("rr_bubble", 64'(when[i] - when[i-1]), 64'd2);
    end
    for (int p = 0; p < NREQ; p++) drive(p, 0, 0, 0, '0, '0);
    repeat (4) tick(acc);

    // Burst cap: 20 write beats on port 1 while port 2 waits with one read.
    seq.delete();
    b = 0;
    drive(1, 1, 1, 0, 24'h200, '0);
    drive(2, 1, 0, 1, 24'h300, '0);
    n = 0;
    while (seq.size() < 21 && n < 100) begin
      tick(acc); n++;
      if (acc != 0) seq.push_back(idx_of(acc));
      if (acc[1]) begin
        b++;
        if (b == 20) drive(1, 0, 0, 0, '0, '0);
        else drive(1, 1, 1, (b == 19), AW'(32'h200 + b), DW'(b));
      end
      if (acc[2]) drive(2, 0, 0, 0, '0, '0);
    end
    check("burst_count", 64'(seq.size()), 64'd21);
    for (int i = 0; i < seq.size(); i++) check("burst_order", 64'(seq[i]), (i == 16) ? 64'd2 : 64'd1);
    repeat (4) tick(acc);

    // Reset one cycle after a read is accepted.
    drive(0, 1, 0, 1, 24'd4194304, '0);
    n = 0;
    do begin tick(acc); n++; end while (acc == 0 && n < 10);
    check("rstmid_accept", 64'(acc), 64'b001);
    drive(0, 0, 0, 0, '0, '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_req_ready", 64'(req_ready), 64'd0);
    check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rstmid_rsp_data", 64'(rsp_data), 64'd0);
    check("rstmid_mem_re", 64'(mem_re), 64'd0);
    check("rstmid_mem_we", 64'(mem_we), 64'd0);
    check("rstmid_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rstmid_mem_wr_addr", 64'(mem_wr_addr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 1, 0, 1, 24'h10, '0);
    drive(1, 1, 0, 1, 24'h11, '0);
    n = 0;
    do begin tick(acc); n++; end while (acc == 0 && n < 10);
    check("rstmid_first_grant", 64'(acc), 64'b001);
    drive(0, 0, 0, 0, '0, '0);
    n = 0;
    do begin tick(acc); n++; end while (acc == 0 && n < 10);
    drive(1, 0, 0, 0, '0, '0);
    repeat (4) tick(acc);

`ifdef EXTMEM_ARB_STATS_EN
    stat_clr = 1'b1;
    tick(acc);
    stat_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 1, AW'(32'h500 + k), DW'(k));
      n = 0;
      do begin tick(acc); n++; end while (acc == 0 && n < 10);
      drive(0, 0, 0, 0, '0, '0);
    end
    @(negedge clk);
    check("stat_five_beats", 64'(stat_beats[31:0]), 64'd5);
    @(posedge clk); #1;
    drive(0, 1, 1, 1, 24'h600, '0);
    tick(acc);
    stat_clr = 1'b1;
    tick(acc);
    check("stat_clr_accept", 64'(acc), 64'b001);
    stat_clr = 1'b0;
    drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    check("stat_clr_wins", 64'(stat_beats[31:0]), 64'd0);
    @(posedge clk); #1;
`endif

    // Random traffic: variable-length bursts, gaps in req_valid, mixed reads/writes.
    acc = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < NREQ; p++) begin
        if (acc[p]) left[p]--;
        if (left[p] == 0 && $urandom_range(0, 5) == 0) left[p] = $urandom_range(1, 24);
        if (acc[p] || !req_valid[p]) begin
          req_we[p] = 1'($urandom_range(0, 1));
          req_addr[p*AW +: AW]  = AW'(32'h400 + $urandom_range(0, 7));
          req_wdata[p*DW +: DW] = DW'($urandom);
        end
        req_valid[p] = (left[p] > 0) && ($urandom_range(0, 4) != 0);
        req_last[p]  = (left[p] == 1);
      end
      tick(acc);
    end
    req_valid = '0;
    repeat (6) tick(acc);
    check("rsp_queue_drained", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
